// File: rtl/move_request_gen.sv
// Turns four raw active-low push-buttons into masked one-cycle move strobes for movement_control.
// Define AUTO_REPEAT_EN for press-and-hold auto-repeat; otherwise one strobe per press or chord change.
module move_request_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned X_MAX           = 159,
    parameter int unsigned Y_MAX           = 119,
    parameter int unsigned CNT_W           = 25
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] key_n,
    input  logic [7:0] cur_x,
    input  logic [7:0] cur_y,
    output logic [3:0] directions,
    output logic       enMove,
    output logic       held
);
    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    if (CNT_W < 1 || CNT_W > 32 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 ||
        longint'(REPEAT_DELAY) > (longint'(1) << CNT_W)) begin : g_param_check
        $error("move_request_gen: repeat counter cannot hold REPEAT_DELAY");
    end

    logic [3:0]     sync1_q, sync2_q, deb_q, d_q, d_last_q, mask;
    logic [DbW-1:0] db_cnt_q [4];
    logic           fire, fire_q, en_q, held_q, chord;
    logic [3:0]     dir_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ~key_n;
            sync2_q <= sync1_q;
        end
    end

    // Each key flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            deb_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_q[i]    <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            d_q      <= '0;
            d_last_q <= '0;
            held_q   <= 1'b0;
        end else begin
            d_q      <= deb_q;
            d_last_q <= d_q;
            held_q   <= |d_q;
        end
    end

    assign chord = (d_q != 4'b0000) && (d_q != d_last_q);

    // Opposing keys cancel; edges of the canvas block outward moves.
    always_comb begin
        mask = d_q;
        if (d_q[3] && d_q[1]) begin
            mask[3] = 1'b0;
            mask[1] = 1'b0;
        end
        if (d_q[2] && d_q[0]) begin
            mask[2] = 1'b0;
            mask[0] = 1'b0;
        end
        if (cur_x == 8'd0)         mask[3] = 1'b0;
        if (cur_x >= 8'(X_MAX))    mask[1] = 1'b0;
        if (cur_y == 8'd0)         mask[2] = 1'b0;
        if (cur_y >= 8'(Y_MAX))    mask[0] = 1'b0;
    end

`ifdef AUTO_REPEAT_EN
    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            StIdle: if (d_q != 4'b0000) state_d = StDelay;
            StDelay: begin
                if (d_q == 4'b0000)                              state_d = StIdle;
                else if (chord)                                  cnt_d = '0;
                else if (cnt_q == CNT_W'(REPEAT_DELAY - 1))      state_d = StRepeat;
                else                                             cnt_d = cnt_q + 1'b1;
            end
            StRepeat: begin
                if (d_q == 4'b0000)                              state_d = StIdle;
                else if (chord)                                  state_d = StDelay;
                else if (cnt_q == CNT_W'(REPEAT_PERIOD - 1))     cnt_d = '0;
                else                                             cnt_d = cnt_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fire = 1'b0;
        case (state_q)
            StIdle:   fire = (d_q != 4'b0000);
            StDelay:  fire = (d_q != 4'b0000) && (chord || cnt_q == CNT_W'(REPEAT_DELAY - 1));
            StRepeat: fire = (d_q != 4'b0000) && (chord || cnt_q == CNT_W'(REPEAT_PERIOD - 1));
            default:  fire = 1'b0;
        endcase
    end
`else
    typedef enum logic [0:0] {StIdle, StHold} state_e;
    state_e state_q, state_d;

    always_ff @(posedge clock) begin
        if (!resetn) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (d_q != 4'b0000) state_d = StHold;
            StHold:  if (d_q == 4'b0000) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fire = 1'b0;
        case (state_q)
            StIdle:  fire = (d_q != 4'b0000);
            StHold:  fire = chord;
            default: fire = 1'b0;
        endcase
    end
`endif

    // The mask is applied one edge after the fire decision so it sees the latest cursor.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            fire_q <= 1'b0;
            en_q   <= 1'b0;
            dir_q  <= '0;
        end else begin
            fire_q <= fire;
            en_q   <= fire_q && (mask != 4'b0000);
            dir_q  <= fire_q ? mask : 4'b0000;
        end
    end

    assign directions = dir_q;
    assign enMove     = en_q;
    assign held       = held_q;
endmodule

// File: tb/tb_move_request_gen.sv
// Bench for move_request_gen: spec-level cycle model checked every cycle plus literal timing checks.
// Follows AUTO_REPEAT_EN the same way the design does.
module tb_move_request_gen;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] key_n  = 4'hF;
    logic [7:0] cur_x  = 8'd50;
    logic [7:0] cur_y  = 8'd50;
    logic [3:0] directions;
    logic       enMove, held;

    move_request_gen #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .X_MAX          (159),
        .Y_MAX          (119),
        .CNT_W          (25)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .key_n     (key_n),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .directions(directions),
        .enMove    (enMove),
        .held      (held)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    int tr    = 0;
    bit chk   = 0;
    int         p_rel [$];
    logic [3:0] p_dir [$];
    bit   held_seen;
    int   held_fall;
    logic prev_held = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] mask_of(input logic [3:0] d, input logic [7:0] x,
                                           input logic [7:0] y);
        logic [3:0] m;
        m = d;
        if (d[3] && d[1]) begin m[3] = 1'b0; m[1] = 1'b0; end
        if (d[2] && d[0]) begin m[2] = 1'b0; m[0] = 1'b0; end
        if (x == 0)   m[3] = 1'b0;
        if (x >= 159) m[1] = 1'b0;
        if (y == 0)   m[2] = 1'b0;
        if (y >= 119) m[0] = 1'b0;
        return m;
    endfunction

    // Model: pressed vector after two sync stages, a DB-deep sample history per key, a one-edge
    // copy of the debounced vector, and fires timed by edge distance from the last fire.
    logic [3:0] m_s1, m_s2, m_deb, m_dv, m_dv_prev, m_dir, m_mk;
    logic [3:0] m_hist [DB];
    logic       m_fire, m_en, m_held, m_f, m_diff;
    int         m_edge, m_last_fire;
    bit         m_last_rep;

    always @(posedge clock) begin
        cyc++;
        if (!resetn) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_dv = '0; m_dv_prev = '0;
            m_dir = '0; m_fire = 0; m_en = 0; m_held = 0;
            for (int j = 0; j < DB; j++) m_hist[j] = '0;
            m_edge = 0; m_last_fire = 0; m_last_rep = 0;
        end else begin
            m_mk   = mask_of(m_dv, cur_x, cur_y);
            m_en   = m_fire && (m_mk != 4'b0000);
            m_dir  = m_fire ? m_mk : 4'b0000;
            m_held = |m_dv;
            m_f    = 0;
            if (m_dv != 4'b0000) begin
                if (m_dv != m_dv_prev) begin
                    m_f = 1; m_last_rep = 0;
                end
`ifdef AUTO_REPEAT_EN
                else if (m_edge - m_last_fire == (m_last_rep ? RP : RD)) begin
                    m_f = 1; m_last_rep = 1;
                end
`endif
            end
            if (m_f) m_last_fire = m_edge;
            m_fire    = m_f;
            m_dv_prev = m_dv;
            m_dv      = m_deb;
            for (int j = DB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = m_s2;
            for (int k = 0; k < 4; k++) begin
                m_diff = 1;
                for (int j = 0; j < DB; j++) if (m_hist[j][k] == m_deb[k]) m_diff = 0;
                if (m_diff) m_deb[k] = ~m_deb[k];
            end
            m_s2 = m_s1;
            m_s1 = ~key_n;
            m_edge++;
        end
    end

    always @(negedge clock) begin
        if (chk) begin
            check("enMove", enMove, m_en);
            check("directions", directions, m_dir);
            check("held", held, m_held);
            if (enMove === 1'b1) begin
                p_rel.push_back(cyc - t0);
                p_dir.push_back(directions);
            end
            if (held === 1'b1) held_seen = 1;
            if (prev_held === 1'b1 && held === 1'b0) held_fall = cyc;
            prev_held = held;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_obs();
        p_rel.delete();
        p_dir.delete();
        held_seen = 0;
        held_fall = -1;
    endtask

    task automatic press(input logic [3:0] kn);
        key_n = kn;
        t0    = cyc + 1;
    endtask

    function automatic int rel_at(input int i);
        return (i < p_rel.size()) ? p_rel[i] : -1;
    endfunction

    function automatic int dir_at(input int i);
        return (i < p_dir.size()) ? int'(p_dir[i]) : -1;
    endfunction

    initial begin
        step(3);
        chk    = 1;
        resetn = 1'b1;

        // Idle, then a 3-cycle glitch on left
        clear_obs();
        t0 = cyc + 1;
        step(100);
        check("idle_pulses", p_rel.size(), 0);
        check("idle_held", held_seen, 0);
        key_n = 4'b0111;
        step(3);
        key_n = 4'hF;
        step(20);
        check("glitch_pulses", p_rel.size(), 0);
        check("glitch_held", held_seen, 0);

        // Hold right for 50 cycles
        clear_obs();
        press(4'b1101);
        step(50);
        key_n = 4'hF;
        tr = cyc + 1;
        step(20);
        check("right_first_at", rel_at(0), 8);
        check("right_first_dir", dir_at(0), 4'b0010);
`ifdef AUTO_REPEAT_EN
        check("right_rep1_at", rel_at(1), 28);
        check("right_rep2_at", rel_at(2), 33);
        check("right_rep3_at", rel_at(3), 38);
        check("right_count", p_rel.size(), 7);
`else
        check("right_count", p_rel.size(), 1);
`endif
        check("held_fall", held_fall - tr, 7);

        // Left+right cancel; adding up gives up only
        clear_obs();
        press(4'b0101);
        step(30);
        check("lr_pulses", p_rel.size(), 0);
        check("lr_held", held_seen, 1);
        clear_obs();
        press(4'b0001);
        step(30);
        check("lru_first_at", rel_at(0), 8);
        check("lru_first_dir", dir_at(0), 4'b0100);
        key_n = 4'hF;
        step(20);

        // Corner (159,0): right+up fully masked until x moves to 158
        cur_x = 8'd159;
        cur_y = 8'd0;
        clear_obs();
        press(4'b1001);
        step(40);
        check("corner_pulses", p_rel.size(), 0);
        cur_x = 8'd158;
        step(30);
`ifdef AUTO_REPEAT_EN
        check("corner_next_at", rel_at(0), 43);
        check("corner_next_dir", dir_at(0), 4'b0010);
`else
        check("corner_next_count", p_rel.size(), 0);
`endif
        key_n = 4'hF;
        step(20);
        cur_x = 8'd50;
        cur_y = 8'd50;

        // Down, add left at cycle 15, then reset mid-repeat
        clear_obs();
        press(4'b1110);
        step(15);
        key_n = 4'b0110;
        step(30);
        check("dl_first_at", rel_at(0), 8);
        check("dl_first_dir", dir_at(0), 4'b0001);
        check("dl_chord_at", rel_at(1), 23);
        check("dl_chord_dir", dir_at(1), 4'b1001);
`ifdef AUTO_REPEAT_EN
        check("dl_rep_at", rel_at(2), 43);
        check("dl_rep_dir", dir_at(2), 4'b1001);
`else
        check("dl_count", p_rel.size(), 2);
`endif
        resetn = 1'b0;
        step(1);
        check("rst_en", enMove, 0);
        check("rst_dir", directions, 0);
        check("rst_held", held, 0);
        step(1);
        resetn = 1'b1;
        clear_obs();
        t0 = cyc + 1;
        step(20);
        check("post_rst_first_at", rel_at(0), 8);
        check("post_rst_first_dir", dir_at(0), 4'b1001);
        key_n = 4'hF;
        step(20);

`ifndef AUTO_REPEAT_EN
        // Long hold yields a single strobe
        clear_obs();
        press(4'b1110);
        step(200);
        check("hold_count", p_rel.size(), 1);
        check("hold_dir", dir_at(0), 4'b0001);
        key_n = 4'hF;
        step(20);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
